// File: rtl/rgb_sbit2wrd.sv
// Serial-bit to LED-word assembler: packs WORD_BITS strobed bits MSB-first into a word.
// Optional macro RGB_SBIT2WRD_PARTIAL_FLUSH_EN emits partial words on stream reset.
module rgb_sbit2wrd #(
  parameter int WORD_BITS = 24,
  parameter int CNT_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 strobe,
  input  logic                 sbit_value,
  input  logic                 stream_reset,
  output logic [WORD_BITS-1:0] out_word,
  output logic                 out_strobe
);

  logic                 r_strobe_d;
  logic [WORD_BITS-1:0] r_shift;
  logic [CNT_W-1:0]     r_bit_cnt;

  logic                 w_event;
  logic                 w_last;
  logic [WORD_BITS-1:0] w_next_word;

  // Left-align a partial word so the first received bit lands in the MSB.
  function automatic logic [WORD_BITS-1:0] partial_align(
    input logic [WORD_BITS-1:0] shift,
    input logic [CNT_W-1:0]     cnt
  );
    int amount;
    amount = WORD_BITS - int'(cnt);
    return shift << amount;
  endfunction

  assign w_event     = strobe & ~r_strobe_d;
  assign w_last      = (r_bit_cnt == CNT_W'(WORD_BITS - 1));
  assign w_next_word = {r_shift[WORD_BITS-2:0], sbit_value};

  always_ff @(posedge clk) begin
    r_strobe_d <= strobe;
    if (rst) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      out_word   <= '0;
      out_strobe <= 1'b0;
    end else begin
      out_strobe <= 1'b0;
      if (w_event) begin
        if (stream_reset) begin
`ifdef RGB_SBIT2WRD_PARTIAL_FLUSH_EN
          if (r_bit_cnt != '0) begin
            out_word   <= partial_align(r_shift, r_bit_cnt);
            out_strobe <= 1'b1;
          end
`endif
          r_shift   <= '0;
          r_bit_cnt <= '0;
        end else if (w_last) begin
          out_word   <= w_next_word;
          out_strobe <= 1'b1;
          r_shift    <= '0;
          r_bit_cnt  <= '0;
        end else begin
          r_shift   <= w_next_word;
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb_sbit2wrd.sv
// Directed bench for rgb_sbit2wrd with a scoreboard of expected words and their due cycles.
module tb_rgb_sbit2wrd;

  logic        clk = 1'b0;
  logic        rst;
  logic        strobe;
  logic        sbit_value;
  logic        stream_reset;
  logic [23:0] out_word;
  logic        out_strobe;

  typedef struct {
    logic [23:0] w;
    int          due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  rgb_sbit2wrd #(.WORD_BITS(24), .CNT_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .strobe       (strobe),
    .sbit_value   (sbit_value),
    .stream_reset (stream_reset),
    .out_word     (out_word),
    .out_strobe   (out_strobe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_strobe === 1'b1) begin
      exp_t e;
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_pulse: out_strobe=1 word=%h at cycle %0d, required no pulse", out_word, cyc);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        assert (out_word === e.w) else begin
          errors++;
          $error("FAIL word_value: got %h, required %h", out_word, e.w);
        end
        checks++;
        assert (cyc === e.due) else begin
          errors++;
          $error("FAIL word_latency: pulse at cycle %0d, required %0d", cyc, e.due);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] req);
    checks++;
    assert (got === req) else begin
      errors++;
      $error("FAIL %s: got %h, required %h", tag, got, req);
    end
  endtask

  // Raise strobe at a negedge, hold for width clocks, then drop it.
  task automatic send_evt(input logic v, input logic sr, input int width,
                          input bit push, input logic [23:0] exp_w);
    exp_t e;
    @(negedge clk);
    strobe = 1'b1; sbit_value = v; stream_reset = sr;
    if (push) begin
      e.w = exp_w; e.due = cyc + 1;
      q.push_back(e);
    end
    repeat (width) @(negedge clk);
    strobe = 1'b0; sbit_value = 1'b0; stream_reset = 1'b0;
  endtask

  task automatic send_bits(input logic [23:0] w, input int n, input bit push);
    for (int i = n - 1; i >= 0; i--) begin
      logic [23:0] t;
      t = w;
      send_evt(t[23 - (n - 1 - i)], 1'b0, 1, push && (i == 0), w);
    end
  endtask

  initial begin
    logic [23:0] p23;
    rst = 1'b1; strobe = 1'b0; sbit_value = 1'b0; stream_reset = 1'b0;

    // Reset
    @(negedge clk);
    check("reset_word", 32'(out_word), 32'h0);
    check("reset_strobe", 32'(out_strobe), 32'h0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_word", 32'(out_word), 32'h0);

    // Strobe widths 1..4 carrying 0,1,0,1, then a 2-clk stream reset
    send_evt(1'b0, 1'b0, 1, 1'b0, 24'h0);
    send_evt(1'b1, 1'b0, 2, 1'b0, 24'h0);
    send_evt(1'b0, 1'b0, 3, 1'b0, 24'h0);
    send_evt(1'b1, 1'b0, 4, 1'b0, 24'h0);
`ifdef RGB_SBIT2WRD_PARTIAL_FLUSH_EN
    send_evt(1'b1, 1'b1, 2, 1'b1, 24'h500000);
`else
    send_evt(1'b1, 1'b1, 2, 1'b0, 24'h0);
`endif
    repeat (2) @(negedge clk);
`ifndef RGB_SBIT2WRD_PARTIAL_FLUSH_EN
    check("stream_reset_word_held", 32'(out_word), 32'h0);
`endif

    // Full word after the stream reset proves the partial bits were dropped
    send_bits(24'hA5C33C, 24, 1'b1);
    repeat (2) @(negedge clk);
    check("word1_held", 32'(out_word), 32'hA5C33C);
    check("strobe_low_after", 32'(out_strobe), 32'h0);

    // 23 bits, stream reset, then a full word
    p23 = 24'h654321;
    send_bits(p23, 23, 1'b0);
`ifdef RGB_SBIT2WRD_PARTIAL_FLUSH_EN
    send_evt(1'b0, 1'b1, 1, 1'b1, 24'h654320);
`else
    send_evt(1'b0, 1'b1, 1, 1'b0, 24'h0);
`endif
    send_bits(24'h123456, 24, 1'b1);
    repeat (2) @(negedge clk);
    check("word2_held", 32'(out_word), 32'h123456);

    // rst after 10 bits, strobe held high across reset release
    send_bits(24'h5A5A5A, 10, 1'b0);
    @(negedge clk);
    rst = 1'b1; strobe = 1'b1; sbit_value = 1'b0;
    @(negedge clk);
    check("rst_mid_strobe", 32'(out_strobe), 32'h0);
    check("rst_mid_word", 32'(out_word), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("held_strobe_no_pulse", 32'(out_strobe), 32'h0);
    strobe = 1'b0;
    send_bits(24'hFFFFFF, 24, 1'b1);
    repeat (3) @(negedge clk);
    check("word3_held", 32'(out_word), 32'hFFFFFF);
    check("queue_drained", 32'(q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
